rotate_sequencer: RTL and testbench

ROTATE_SEQUENCER -- requirements
Module: rotate_sequencer

---
 rtl/rotate_sequencer.sv | 101 ++++++++++
 tb/tb_rotate_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rotate_sequencer.sv
// Command-driven shift/rotate sequencer: loads a value, applies N single-bit
// steps of the selected mode, then reports the final value with a done pulse.
module rotate_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0] cmd_amount,
    input  logic [1:0]       cmd_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] Q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    state_t           state;
    logic [1:0]       mode;
    logic [AMT_W-1:0] count;
    logic [WIDTH-1:0] q_step_c;

    // One single-bit step of the captured mode applied to the live register.
    always_comb begin
        q_step_c = Q;
        case (mode)
            MODE_ROR: q_step_c = {Q[0], Q[WIDTH-1:1]};
            MODE_ROL: q_step_c = {Q[WIDTH-2:0], Q[WIDTH-1]};
            MODE_ASR: q_step_c = {Q[WIDTH-1], Q[WIDTH-1:1]};
            default:  q_step_c = {1'b0, Q[WIDTH-1:1]};
        endcase
    end

    // Handshake flags are registered alongside the state so they always match it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            Q         <= '0;
            result    <= '0;
            count     <= '0;
            mode      <= '0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        Q         <= cmd_data;
                        mode      <= cmd_mode;
                        count     <= cmd_amount;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_amount != '0) begin
                            state <= SHIFT;
                        end else begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= cmd_data;
                        end
                    end
                end
                SHIFT: begin
                    Q     <= q_step_c;
                    count <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= q_step_c;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer: hand-computed results, latency,
// done-pulse shape, reset abort and back-pressure behaviour.
module tb_rotate_sequencer;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic [2:0] cmd_amount;
    logic [1:0] cmd_mode;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic [3:0] Q;

    int checks = 0;
    int errors = 0;

    rotate_sequencer #(.WIDTH(4), .AMT_W(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_amount (cmd_amount),
        .cmd_mode   (cmd_mode),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .Q          (Q)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command and follow it to completion and back to IDLE.
    task automatic do_cmd(input string tag, input logic [3:0] data, input logic [1:0] mode,
                          input logic [2:0] amt, input logic [3:0] exp_res);
        int lat;
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_data   = data;
        cmd_mode   = mode;
        cmd_amount = amt;
        tick();
        cmd_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(int'(amt) + 1));
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_q"}, 32'(Q), 32'(exp_res));
        tick();
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_idle"}, {30'd0, cmd_ready, busy}, 32'b10);
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_data   = '0;
        cmd_amount = '0;
        cmd_mode   = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_q", 32'(Q), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {29'd0, cmd_ready, busy, done}, 32'b100);

        do_cmd("ror1", 4'b1001, 2'b00, 3'd1, 4'b1100);

        // Rotate left by 2 with intermediate values
        cmd_valid = 1'b1; cmd_data = 4'b1001; cmd_mode = 2'b01; cmd_amount = 3'd2;
        tick();
        cmd_valid = 1'b0;
        check("rol2_load", 32'(Q), 32'b1001);
        tick();
        check("rol2_s1", 32'(Q), 32'b0011);
        check("rol2_s1_done", 32'(done), 32'd0);
        tick();
        check("rol2_s2", 32'(Q), 32'b0110);
        check("rol2_done", 32'(done), 32'd1);
        check("rol2_result", 32'(result), 32'b0110);
        tick();
        check("rol2_done_once", 32'(done), 32'd0);
        tick();
        check("rol2_no_second", 32'(done), 32'd0);

        do_cmd("asr3", 4'b1000, 2'b10, 3'd3, 4'b1111);
        do_cmd("lsr3", 4'b1000, 2'b11, 3'd3, 4'b0001);
        do_cmd("zero", 4'b1010, 2'b00, 3'd0, 4'b1010);
        do_cmd("wrap4", 4'b0110, 2'b00, 3'd4, 4'b0110);
        do_cmd("rol7", 4'b0001, 2'b01, 3'd7, 4'b1000);

        // Idle hold
        cmd_data = 4'b0101;
        tick();
        tick();
        check("idle_hold", 32'(Q), 32'b1000);

        // Reset in the second SHIFT cycle of ror 1001 by 3
        cmd_valid = 1'b1; cmd_data = 4'b1001; cmd_mode = 2'b00; cmd_amount = 3'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("abort_s1", 32'(Q), 32'b1100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_q", 32'(Q), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", {29'd0, cmd_ready, busy, done}, 32'b100);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_ready", 32'(cmd_ready), 32'd1);

        // Reset wins over a simultaneous handshake
        reset = 1'b1; cmd_valid = 1'b1; cmd_data = 4'b1111; cmd_amount = 3'd0;
        tick();
        reset = 1'b0; cmd_valid = 1'b0;
        check("rst_prio_q", 32'(Q), 32'd0);
        tick();
        check("rst_prio_flags", {29'd0, cmd_ready, busy, done}, 32'b100);

        // Back-pressure: cmd_valid stays high with changing payload
        cmd_valid = 1'b1; cmd_data = 4'b1001; cmd_mode = 2'b00; cmd_amount = 3'd3;
        tick();
        cmd_data = 4'b0110; cmd_mode = 2'b01; cmd_amount = 3'd1;
        tick();
        check("bp_s1", 32'(Q), 32'b1100);
        cmd_data = 4'b1111; cmd_mode = 2'b10;
        tick();
        check("bp_s2", 32'(Q), 32'b0110);
        cmd_data = 4'b0101; cmd_mode = 2'b11; cmd_amount = 3'd0;
        tick();
        check("bp_done", 32'(done), 32'd1);
        check("bp_result", 32'(result), 32'b0011);
        tick();
        check("bp_idle", {29'd0, cmd_ready, busy, done}, 32'b100);
        check("bp_idle_q", 32'(Q), 32'b0011);
        tick();
        cmd_valid = 1'b0;
        check("bp_next_done", 32'(done), 32'd1);
        check("bp_next_result", 32'(result), 32'b0101);
        tick();
        check("bp_next_idle", 32'(cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
